// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, draw coordinates for the renderer,
// and a sync/blank delay line that lines the registered sync and data-enable up with the renderer's RGB.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic        pix_clk,
    input  logic        rst,
    output logic [9:0]  draw_x,
    output logic [9:0]  draw_y,
    output logic        draw_en,
    output logic        line_start,
    output logic        frame_start,
    input  logic [23:0] rgb_in,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic [15:0] frame_cnt
);
    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic        SYNC_OFF = ~SYNC_POL;
    // Stage layout {hsync level, vsync level, de}; idle is inactive sync, blanked.
    localparam logic [2:0]  STG_IDLE = {SYNC_OFF, SYNC_OFF, 1'b0};

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          de0;
    logic          hs0;
    logic          vs0;
    logic [2:0]    stg0;
    logic [2:0]    dly [PIPE_DLY];
    logic          col_de;
    logic [23:0]   rgb_q;

    assign h_last = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt == CW'(V_TOTAL - 1));

    // Raster counters and completed-frame count
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
                v_cnt     <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                v_cnt <= v_cnt + CW'(1);
            end
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    assign de0  = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
    assign hs0  = (h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_END));
    assign vs0  = (v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_END));
    assign stg0 = {hs0 ? SYNC_POL : SYNC_OFF, vs0 ? SYNC_POL : SYNC_OFF, de0};

    assign draw_x      = h_cnt;
    assign draw_y      = v_cnt;
    assign draw_en     = de0;
    assign line_start  = (h_cnt == '0);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);

    // Sync/blank delay line; polarity is applied before the first stage so the outputs come straight off flops
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PIPE_DLY); i++) begin
                dly[i] <= STG_IDLE;
            end
        end else begin
            dly[0] <= stg0;
            for (int i = 1; i < int'(PIPE_DLY); i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign hsync = dly[PIPE_DLY-1][2];
    assign vsync = dly[PIPE_DLY-1][1];
    assign vde   = dly[PIPE_DLY-1][0];

    // Mask with the de one stage ahead of the output so colour lands in the same cycle as its vde
    if (PIPE_DLY == 1) begin : g_col_d1
        assign col_de = de0;
    end else begin : g_col_dn
        assign col_de = dly[PIPE_DLY-2][0];
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= col_de ? rgb_in : 24'd0;
        end
    end

    assign red   = rgb_q[23:16];
    assign green = rgb_q[15:8];
    assign blue  = rgb_q[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three parameterisations driven by randomised renderers and
// compared every cycle against an arithmetic model of the raster indexed by cycles since reset.
`timescale 1ns/1ps
module tb_video_timing_gen;
    // Instance A: default 640x480 timing, PIPE_DLY=2, active-low sync
    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam int A_D  = 2;
    // Instance B: small raster, PIPE_DLY=1, active-high sync
    localparam int B_HA = 16, B_HF = 4, B_HS = 6, B_HB = 4;
    localparam int B_VA = 10, B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_D  = 1;
    localparam int B_FT = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);
    // Instance C: small raster, PIPE_DLY=3, active-low sync
    localparam int C_HA = 12, C_HF = 3, C_HS = 5, C_HB = 4;
    localparam int C_VA = 8,  C_VF = 3, C_VS = 3, C_VB = 2;
    localparam int C_D  = 3;
    localparam int C_FT = (C_HA + C_HF + C_HS + C_HB) * (C_VA + C_VF + C_VS + C_VB);

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        en;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    logic [9:0]  dx_a, dy_a, dx_b, dy_b, dx_c, dy_c;
    logic        en_a, ls_a, fs_a, hs_a, vs_a, de_a;
    logic        en_b, ls_b, fs_b, hs_b, vs_b, de_b;
    logic        en_c, ls_c, fs_c, hs_c, vs_c, de_c;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic [15:0] fc_a, fc_b, fc_c;
    logic [23:0] rgb_in_a, rgb_in_b, rgb_in_c;

    logic [7:0]  salt_now;
    logic [7:0]  hist   [8];
    logic [23:0] ring_a [8];
    logic [23:0] ring_c [8];

    int n_pass, n_fail, n_total;
    int cnt_b, cnt_c;

    always #5 clk = ~clk;

    // PIPE_DLY=1 renderer answers combinationally from the current draw coordinates
    assign rgb_in_b = {dx_b[7:0], dy_b[7:0], salt_now};

    video_timing_gen u_a (
        .pix_clk(clk), .rst(rst), .draw_x(dx_a), .draw_y(dy_a), .draw_en(en_a),
        .line_start(ls_a), .frame_start(fs_a), .rgb_in(rgb_in_a),
        .red(r_a), .green(g_a), .blue(b_a), .hsync(hs_a), .vsync(vs_a), .vde(de_a),
        .frame_cnt(fc_a)
    );

    video_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .SYNC_POL(1'b1), .PIPE_DLY(B_D)
    ) u_b (
        .pix_clk(clk), .rst(rst), .draw_x(dx_b), .draw_y(dy_b), .draw_en(en_b),
        .line_start(ls_b), .frame_start(fs_b), .rgb_in(rgb_in_b),
        .red(r_b), .green(g_b), .blue(b_b), .hsync(hs_b), .vsync(vs_b), .vde(de_b),
        .frame_cnt(fc_b)
    );

    video_timing_gen #(
        .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
        .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB),
        .SYNC_POL(1'b0), .PIPE_DLY(C_D)
    ) u_c (
        .pix_clk(clk), .rst(rst), .draw_x(dx_c), .draw_y(dy_c), .draw_en(en_c),
        .line_start(ls_c), .frame_start(fs_c), .rgb_in(rgb_in_c),
        .red(r_c), .green(g_c), .blue(b_c), .hsync(hs_c), .vsync(vs_c), .vde(de_c),
        .frame_cnt(fc_c)
    );

    // Expected outputs k cycles after reset release; outputs show the raster position of cycle k-d
    function automatic obs_t model(input int k, input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit pol, input int d);
        obs_t m;
        int ht, vt, ft, p, q, hq, vq;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        ft = ht * vt;
        p  = k % ft;
        m.x   = 10'(p % ht);
        m.y   = 10'(p / ht);
        m.en  = ((p % ht) < ha) && ((p / ht) < va);
        m.ls  = ((p % ht) == 0);
        m.fs  = (p == 0);
        m.fc  = 16'(k / ft);
        m.hs  = ~pol;
        m.vs  = ~pol;
        m.de  = 1'b0;
        m.rgb = '0;
        if (k >= d) begin
            q  = (k - d) % ft;
            hq = q % ht;
            vq = q / ht;
            if (hq >= ha + hf && hq < ha + hf + hsw) m.hs = pol;
            if (vq >= va + vf && vq < va + vf + vsw) m.vs = pol;
            if (hq < ha && vq < va) begin
                m.de  = 1'b1;
                m.rgb = {8'(hq), 8'(vq), hist[3'(k - d)]};
            end
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_all(input string nm, input int k, input obs_t o, input obs_t e);
        string p;
        p = $sformatf("%s@%0d", nm, k);
        check({p, ".draw_x"},      32'(o.x),   32'(e.x));
        check({p, ".draw_y"},      32'(o.y),   32'(e.y));
        check({p, ".draw_en"},     32'(o.en),  32'(e.en));
        check({p, ".line_start"},  32'(o.ls),  32'(e.ls));
        check({p, ".frame_start"}, 32'(o.fs),  32'(e.fs));
        check({p, ".hsync"},       32'(o.hs),  32'(e.hs));
        check({p, ".vsync"},       32'(o.vs),  32'(e.vs));
        check({p, ".vde"},         32'(o.de),  32'(e.de));
        check({p, ".rgb"},         32'(o.rgb), 32'(e.rgb));
        check({p, ".frame_cnt"},   32'(o.fc),  32'(e.fc));
    endtask

    task automatic check_all(input int k);
        cmp_all("A", k, {dx_a, dy_a, en_a, ls_a, fs_a, hs_a, vs_a, de_a, r_a, g_a, b_a, fc_a},
                model(k, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0, A_D));
        cmp_all("B", k, {dx_b, dy_b, en_b, ls_b, fs_b, hs_b, vs_b, de_b, r_b, g_b, b_b, fc_b},
                model(k, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, B_D));
        cmp_all("C", k, {dx_c, dy_c, en_c, ls_c, fs_c, hs_c, vs_c, de_c, r_c, g_c, b_c, fc_c},
                model(k, C_HA, C_HF, C_HS, C_HB, C_VA, C_VF, C_VS, C_VB, 1'b0, C_D));
    endtask

    // Check cycle k, tally vde per frame, then present the renderers' data for cycle k
    task automatic step(input int k);
        check_all(k);
        if (k >= B_D) begin
            cnt_b += int'(de_b);
            if ((k - B_D) % B_FT == B_FT - 1) begin
                check($sformatf("B.vde_per_frame@%0d", k), 32'(cnt_b), 32'(B_HA * B_VA));
                cnt_b = 0;
            end
        end
        if (k >= C_D) begin
            cnt_c += int'(de_c);
            if ((k - C_D) % C_FT == C_FT - 1) begin
                check($sformatf("C.vde_per_frame@%0d", k), 32'(cnt_c), 32'(C_HA * C_VA));
                cnt_c = 0;
            end
        end
        salt_now        = 8'($urandom);
        hist[3'(k)]     = salt_now;
        ring_a[3'(k)]   = {dx_a[7:0], dy_a[7:0], salt_now};
        ring_c[3'(k)]   = {dx_c[7:0], dy_c[7:0], salt_now};
        rgb_in_a        = ring_a[3'(k - (A_D - 1))];
        rgb_in_c        = ring_c[3'(k - (C_D - 1))];
    endtask

    initial begin
        int k1;
        n_pass   = 0;
        n_fail   = 0;
        n_total  = 0;
        cnt_b    = 0;
        cnt_c    = 0;
        salt_now = 8'h00;
        rgb_in_a = '0;
        rgb_in_c = '0;
        for (int i = 0; i < 8; i++) begin
            hist[i]   = '0;
            ring_a[i] = '0;
            ring_c[i] = '0;
        end
        rst = 1'b1;

        // Power-on reset held for 5 cycles
        repeat (5) begin
            @(posedge clk);
            #1;
            check_all(0);
        end
        rst = 1'b0;
        step(0);

        // Three-plus frames of the small rasters, first lines of the default raster
        k1 = 1600 + int'($urandom_range(60, 0));
        for (int k = 1; k <= k1; k++) begin
            @(posedge clk);
            #1;
            step(k);
        end

        // Asynchronous reset in mid-frame: values must drop before any clock edge
        #2;
        rst = 1'b1;
        #1;
        check_all(0);
        @(posedge clk);
        #1;
        check_all(0);
        rst   = 1'b0;
        cnt_b = 0;
        cnt_c = 0;
        step(0);

        for (int k = 1; k <= 1100; k++) begin
            @(posedge clk);
            #1;
            step(k);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
